// File: rtl/memory_reader.sv
// memory_reader: AXI4 read master that replays a stored frame as an
// AXI4-Stream, one INCR burst per row, one burst outstanding at a time.
module memory_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_error,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;       // start address of the current row burst
  logic [7:0]            len;        // width-1, doubles as the last-beat index
  logic [15:0]           last_row;   // height-1
  logic [15:0]           row;
  logic [7:0]            beat;
  logic                  err;

  logic                  start_ok;
  logic                  in_data;
  logic                  xfer;
  logic                  row_end;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  unused_inputs;

  // rid and rlast carry no control meaning; the beat counter decides row end
  assign unused_inputs = ^{rid, rlast};

  assign start_ok = frame_ready && (frame_width != 16'd0) && (frame_height != 16'd0)
                    && (frame_width <= 16'd256);
  assign in_data  = (state == ST_DATA);
  assign xfer     = in_data && rvalid && m_axis_tready;
  assign row_end  = xfer && (beat == len);
  // bytes per row; width is at most 256 so 9 bits hold it before scaling
  assign stride   = ADDR_WIDTH'({1'b0, len} + 9'd1) << SIZE;

  // Frame sequencing: accept start, issue row bursts, count beats, flag errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      len      <= '0;
      last_row <= '0;
      row      <= '0;
      beat     <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            addr     <= base_addr_in;
            len      <= 8'(frame_width - 16'd1);
            last_row <= frame_height - 16'd1;
            row      <= '0;
            beat     <= '0;
            err      <= 1'b0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (xfer) begin
            if (rresp != 2'b00) err <= 1'b1;
            if (row_end) begin
              beat <= '0;
              if (row == last_row) begin
                state <= ST_DONE;
              end else begin
                row   <= row + 16'd1;
                addr  <= addr + stride;
                state <= ST_ADDR;
              end
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address channel: fields come straight from registers, so they stay put until arready
  always_comb begin
    arid    = '0;
    araddr  = addr;
    arlen   = len;
    arsize  = 3'(SIZE);
    arburst = 2'b01;
    arvalid = (state == ST_ADDR);
  end

  // Data path: zero-latency pass-through of R beats onto the stream while in DATA
  always_comb begin
    rready        = in_data && m_axis_tready;
    m_axis_tvalid = in_data && rvalid;
    m_axis_tdata  = in_data ? rdata : '0;
    m_axis_tlast  = in_data && (beat == len);
    m_axis_tuser  = in_data && (row == 16'd0) && (beat == 8'd0);
  end

  // Status outputs
  always_comb begin
    busy       = (state == ST_ADDR) || (state == ST_DATA);
    frame_done = (state == ST_DONE);
    rd_error   = err;
  end

endmodule

// File: tb/tb_memory_reader.sv
// tb_memory_reader: directed bench with a reactive AXI read slave and a stream
// sink; drives and samples on the falling edge.
module tb_memory_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_ready;
  logic [31:0] base_addr_in;
  logic [15:0] frame_width, frame_height;
  logic        busy, frame_done, rd_error;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;

  always #5 clk = ~clk;

  memory_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .base_addr_in(base_addr_in),
    .frame_width(frame_width), .frame_height(frame_height), .busy(busy),
    .frame_done(frame_done), .rd_error(rd_error), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    string name;
    int    mode;       // 0: always ready, 1: toggling with a 5-cycle stall
    int    ardly;      // arready delay in cycles
    int    errb;       // beat index carrying SLVERR, -1 for none
    int    exp_efirst; // beats seen when rd_error first observed high
    logic  exp_err;
  } scen_t;

  logic [31:0] mem [0:255];

  int ar_delay, tready_mode, err_beat, cyc;
  logic        outstanding;
  logic [31:0] b_addr;
  logic [7:0]  b_len, ridx;
  int          b_idx, ar_wait;

  beat_t       got [0:31];
  int          nbeats, ar_cnt, done_cnt, err_first;
  logic [31:0] ar_addr_log [0:7];
  logic [7:0]  ar_len_log [0:7];
  int          viol_hold, viol_rready, viol_busy, viol_ar;
  logic        busy_seen, prev_arv, prev_busy;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;

  int n_checks, n_pass;

  // Reactive slave + sink: drive on the falling edge, then record what the next rising edge will accept
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
      b_idx = 0;
      ar_wait = 0;
      prev_arv = 1'b0;
    end
    cyc = cyc + 1;
    if (tready_mode == 0) m_axis_tready = 1'b1;
    else m_axis_tready = (cyc % 2 == 0) && !(cyc >= 9 && cyc < 14);
    arready = arvalid && (ar_wait >= ar_delay);
    ridx   = b_addr[9:2] + b_idx[7:0];
    rvalid = outstanding;
    rdata  = outstanding ? mem[ridx] : 32'd0;
    rresp  = (outstanding && nbeats == err_beat) ? 2'b10 : 2'b00;
    rlast  = outstanding && (b_idx[7:0] == b_len);
    rid    = 4'd0;
    #1;
    if (rst_n) begin
      if (rready !== (outstanding && m_axis_tready)) viol_rready++;
      if (arvalid && outstanding) viol_ar++;
      if (arvalid && prev_arv && (araddr !== prev_addr || arlen !== prev_len)) viol_hold++;
      prev_arv  = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (rd_error && err_first < 0) err_first = nbeats;
      if (m_axis_tvalid && m_axis_tready) begin
        if (nbeats < 32) got[nbeats] = '{m_axis_tdata, m_axis_tlast, m_axis_tuser};
        nbeats++;
        if (b_idx[7:0] == b_len) outstanding = 1'b0;
        else b_idx++;
      end
      if (arvalid) begin
        if (arready) begin
          if (ar_cnt < 8) begin
            ar_addr_log[ar_cnt] = araddr;
            ar_len_log[ar_cnt]  = arlen;
          end
          ar_cnt++;
          b_addr = araddr;
          b_len  = arlen;
          b_idx  = 0;
          outstanding = 1'b1;
          ar_wait = 0;
        end else begin
          ar_wait++;
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (busy || !prev_busy) viol_busy++;
      end
      if (busy) busy_seen = 1'b1;
      prev_busy = busy;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_logs();
    nbeats = 0; ar_cnt = 0; done_cnt = 0; err_first = -1; cyc = 0;
    viol_hold = 0; viol_rready = 0; viol_busy = 0; viol_ar = 0; busy_seen = 1'b0;
  endtask

  task automatic start(input logic [15:0] w, input logic [15:0] h, input logic [31:0] b,
                       input logic exp_busy);
    @(negedge clk);
    frame_width = w; frame_height = h; base_addr_in = b; frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    #2;
    chk("busy_after_start", 64'(busy), 64'(exp_busy));
    if (exp_busy) chk("rd_error_cleared_on_start", 64'(rd_error), 64'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) chk("frame_done_timeout", 64'(0), 64'(1));
    repeat (5) @(negedge clk);
  endtask

  task automatic check_clean_frame(input string tag);
    chk({tag, "_hold_viol"}, 64'(viol_hold), 64'(0));
    chk({tag, "_rready_viol"}, 64'(viol_rready), 64'(0));
    chk({tag, "_busy_viol"}, 64'(viol_busy), 64'(0));
    chk({tag, "_ar_overlap_viol"}, 64'(viol_ar), 64'(0));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
  endtask

  beat_t exp_b [0:7];
  scen_t sc [0:3];

  initial begin
    n_checks = 0; n_pass = 0;
    ar_delay = 0; tready_mode = 0; err_beat = -1;
    b_addr = 32'd0; b_len = 8'd0; prev_busy = 1'b0;
    rst_n = 1'b0; frame_ready = 1'b0; base_addr_in = 32'd0;
    frame_width = 16'd0; frame_height = 16'd0;
    m_axis_tready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    clear_logs();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[8'h40 + i] = 32'(i + 1);
    mem[8'h80] = 32'h0000_00AA;

    exp_b[0] = '{32'd1, 1'b0, 1'b1};
    exp_b[1] = '{32'd2, 1'b0, 1'b0};
    exp_b[2] = '{32'd3, 1'b0, 1'b0};
    exp_b[3] = '{32'd4, 1'b1, 1'b0};
    exp_b[4] = '{32'd5, 1'b0, 1'b0};
    exp_b[5] = '{32'd6, 1'b0, 1'b0};
    exp_b[6] = '{32'd7, 1'b0, 1'b0};
    exp_b[7] = '{32'd8, 1'b1, 1'b0};

    sc[0] = '{"basic",        0, 0, -1, -1, 1'b0};
    sc[1] = '{"backpressure", 1, 0, -1, -1, 1'b0};
    sc[2] = '{"addr_hold",    0, 3, -1, -1, 1'b0};
    sc[3] = '{"read_error",   0, 0,  5,  6, 1'b1};

    // Reset state
    @(negedge clk);
    #2;
    chk("reset_ctrl_outputs",
        64'({arvalid, rready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done, rd_error}),
        64'(0));
    chk("reset_araddr", 64'(araddr), 64'(0));
    chk("arsize", 64'(arsize), 64'(2));
    chk("arburst", 64'(arburst), 64'(1));
    chk("arid", 64'(arid), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven 4x2 frames at 0x100
    for (int s = 0; s < 4; s++) begin
      clear_logs();
      tready_mode = sc[s].mode; ar_delay = sc[s].ardly; err_beat = sc[s].errb;
      start(16'd4, 16'd2, 32'h100, 1'b1);
      wait_done();
      chk({sc[s].name, "_nbeats"}, 64'(nbeats), 64'(8));
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s_beat%0d", sc[s].name, i),
            64'({got[i].data, got[i].last, got[i].user}),
            64'({exp_b[i].data, exp_b[i].last, exp_b[i].user}));
      chk({sc[s].name, "_ar_count"}, 64'(ar_cnt), 64'(2));
      chk({sc[s].name, "_ar0"}, 64'({ar_addr_log[0], ar_len_log[0]}), 64'({32'h100, 8'd3}));
      chk({sc[s].name, "_ar1"}, 64'({ar_addr_log[1], ar_len_log[1]}), 64'({32'h110, 8'd3}));
      chk({sc[s].name, "_rd_error"}, 64'(rd_error), 64'(sc[s].exp_err));
      chk({sc[s].name, "_err_first"}, 64'(err_first), 64'(sc[s].exp_efirst));
      check_clean_frame(sc[s].name);
    end
    tready_mode = 0; ar_delay = 0; err_beat = -1;

    // Illegal starts are ignored
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      if (k == 0) start(16'd4, 16'd0, 32'h100, 1'b0);
      else if (k == 1) start(16'd0, 16'd2, 32'h100, 1'b0);
      else start(16'd257, 16'd1, 32'h100, 1'b0);
      repeat (20) @(negedge clk);
      chk($sformatf("illegal%0d_busy_seen", k), 64'(busy_seen), 64'(0));
      chk($sformatf("illegal%0d_ar_count", k), 64'(ar_cnt), 64'(0));
      chk($sformatf("illegal%0d_done", k), 64'(done_cnt), 64'(0));
    end

    // Start while busy is dropped
    clear_logs();
    start(16'd4, 16'd2, 32'h100, 1'b1);
    repeat (2) @(negedge clk);
    frame_width = 16'd1; frame_height = 16'd1; base_addr_in = 32'h200; frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);
    chk("overlap_done_count", 64'(done_cnt), 64'(1));
    chk("overlap_nbeats", 64'(nbeats), 64'(8));
    chk("overlap_ar_count", 64'(ar_cnt), 64'(2));

    // 1x1 frame: tuser and tlast on the same beat, arlen 0
    clear_logs();
    start(16'd1, 16'd1, 32'h200, 1'b1);
    wait_done();
    chk("one_px_beat", 64'({got[0].data, got[0].last, got[0].user}), 64'({32'hAA, 1'b1, 1'b1}));
    chk("one_px_ar0", 64'({ar_addr_log[0], ar_len_log[0]}), 64'({32'h200, 8'd0}));
    chk("one_px_nbeats", 64'(nbeats), 64'(1));
    check_clean_frame("one_px");

    // Address wrap-around across the top of the address space
    clear_logs();
    start(16'd4, 16'd2, 32'hFFFF_FFF8, 1'b1);
    wait_done();
    chk("wrap_ar0", 64'({ar_addr_log[0], ar_len_log[0]}), 64'({32'hFFFF_FFF8, 8'd3}));
    chk("wrap_ar1", 64'({ar_addr_log[1], ar_len_log[1]}), 64'({32'h0000_0008, 8'd3}));
    chk("wrap_done", 64'(done_cnt), 64'(1));

    // Maximum width 256, one row
    clear_logs();
    start(16'd256, 16'd1, 32'h0, 1'b1);
    wait_done();
    chk("w256_arlen", 64'(ar_len_log[0]), 64'(8'hFF));
    chk("w256_nbeats", 64'(nbeats), 64'(256));
    chk("w256_first_user", 64'(got[0].user), 64'(1));
    check_clean_frame("w256");

    // Reset mid-frame, then a clean frame
    clear_logs();
    start(16'd4, 16'd2, 32'h100, 1'b1);
    begin
      int n = 0;
      while (nbeats < 6 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (nbeats < 6) chk("midreset_wait_timeout", 64'(0), 64'(1));
    end
    rst_n = 1'b0;
    #2;
    chk("midreset_ctrl_outputs",
        64'({arvalid, rready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done, rd_error}),
        64'(0));
    chk("midreset_araddr", 64'(araddr), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    start(16'd4, 16'd2, 32'h100, 1'b1);
    wait_done();
    chk("after_reset_nbeats", 64'(nbeats), 64'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("after_reset_beat%0d", i),
          64'({got[i].data, got[i].last, got[i].user}),
          64'({exp_b[i].data, exp_b[i].last, exp_b[i].user}));
    check_clean_frame("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_reader.md
Name: memory_reader

Overview:
AXI4 read master that fetches one stored frame from external memory and replays it as an AXI4-Stream master, one row per read burst. It is the read-side counterpart of memory_writer. It is triggered by that block's frame_ready / base_addr_out pair and feeds the downstream pixel pipeline. Stream framing matches the writer's input: tuser on the first pixel of a frame, tlast on the last pixel of each row.

Parameters:
DATA_WIDTH, 32, pixel/bus width in bits (power of two, >= 8)
ADDR_WIDTH, 32, AXI address width
ID_WIDTH, 4, AXI ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_ready  in  1  start pulse; frame stored at base_addr_in
base_addr_in  in  ADDR_WIDTH  byte address of pixel 0
frame_width  in  16  pixels per row (burst length)
frame_height  in  16  rows per frame
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last pixel accepted
rd_error  out  1  sticky: any rresp != OKAY during current/last frame
arid  out  ID_WIDTH  constant 0
araddr  out  ADDR_WIDTH  row burst start address
arlen  out  8  frame_width-1
arsize  out  3  log2(DATA_WIDTH/8)
arburst  out  2  2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  address ready
rid  in  ID_WIDTH  ignored
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response
rlast  in  1  burst last (informational)
rvalid  in  1  read data valid
rready  out  1  read data ready
m_axis_tdata  out  DATA_WIDTH  pixel
m_axis_tvalid  out  1  pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of row
m_axis_tuser  out  1  first pixel of frame

Behaviour:
- Reset: state IDLE. arvalid, rready, m_axis_tvalid, tlast, tuser, busy, frame_done, rd_error = 0. araddr = 0. Row and beat counters = 0. Reset mid-burst aborts immediately; outstanding R beats after reset are not the block's concern.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: frame_ready sampled only here. On accept, latch base, width, and height; clear rd_error; set busy; go to ADDR with araddr = base.
  - frame_ready is ignored (no pulse, stays IDLE) if width == 0, height == 0, or width > 256.
  - frame_ready while busy is dropped; there is no queuing.
- ADDR: arvalid = 1. araddr, arlen, arsize, and arburst are held stable until arready. On arvalid && arready, go to DATA next cycle with arvalid = 0.
- DATA: zero-latency combinational pass-through.
  - m_axis_tvalid = rvalid; rready = m_axis_tready; m_axis_tdata = rdata.
  - A beat transfers when rvalid && m_axis_tready.
  - m_axis_tlast = (beat == width-1).
  - m_axis_tuser = (row == 0 && beat == 0).
- Beat counter: increments per transfer and is authoritative for row end; rlast is not used for control.
- Row end, on the transfer with beat == width-1:
  - beat <= 0.
  - If row == height-1, go to DONE.
  - Otherwise row++, araddr += width*(DATA_WIDTH/8), and go to ADDR.
  - Address arithmetic is ADDR_WIDTH wide with wrap-around. The next AR is issued only after the previous burst completes (one outstanding burst).
- rd_error: set on any transfer with rresp != 2'b00; held until the next accepted start. Data is still forwarded.
- DONE: frame_done = 1 for exactly one cycle, busy = 0 in the same cycle, then IDLE. A frame_ready pulse may be accepted in the cycle after DONE.
- Outside DATA: rready = 0 and m_axis_tvalid = 0.

Test Plan:
- Basic transfer:
  - Stimulus: width=4, height=2, base=0x100; memory holds 1..8 at 0x100..0x11C; ready slave.
  - Required: AR 0x100 len 3, then AR 0x110 len 3. Stream 1..8 with tuser on beat 0 only, tlast on beats 3 and 7. frame_done pulses once; busy falls the same cycle.
- Backpressure: same frame, m_axis_tready toggling 1/0 each cycle plus a 5-cycle stall mid-row -> rready mirrors tready, no beat lost or duplicated, order 1..8 preserved.
- Address hold: arready delayed 3 cycles on each burst -> araddr/arlen stable while arvalid is high; no DATA entry before the handshake.
- Illegal/overlapping starts:
  - height=0 -> busy never rises, no AR, no frame_done.
  - Valid frame_ready pulse while busy -> ignored; exactly one frame output.
- Read error: rresp=2'b10 on beat 5 -> rd_error rises that cycle and holds past frame_done; the next accepted start clears it.
- Reset mid-frame: rst_n low during row 1 beat 2 -> all outputs 0 asynchronously; a new 4x2 frame afterwards plays cleanly from tuser.
